// File: rtl/exc_commit_seq.sv
// Exception/ERET commit sequencer at the MEM->WB boundary.
// Arbitrates cause, drains the bus, writes CP0 and issues a flushing redirect.
module exc_commit_seq #(
   parameter logic [31:0] VEC_BASE  = 32'hBFC0_0380,
   parameter int          DRAIN_MAX = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_Valid,
   input  logic [31:0] MEM_PC,
   input  logic        MEM_InDelaySlot,
   input  logic [8:0]  MEM_ExcReq,
   input  logic        MEM_Eret,
   input  logic [31:0] MEM_BadVAddr,
   input  logic [31:0] CP0_EPC,
   input  logic        Mem_Outstanding,
   input  logic        Redirect_ready,
   output logic        Kill_MEM,
   output logic        Stall_all,
   output logic        Flush_all,
   output logic        CP0_WrEn,
   output logic        CP0_ExlClr,
   output logic [4:0]  CP0_ExcCode,
   output logic [31:0] CP0_EPC_out,
   output logic        CP0_BD,
   output logic        CP0_BadVAddrWr,
   output logic [31:0] CP0_BadVAddr,
   output logic        Redirect_valid,
   output logic [31:0] Redirect_PC,
   output logic        Busy
);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      COMMIT,
      REDIRECT
   } state_t;

   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);

   state_t      state;
   logic [7:0]  cnt;
   logic [4:0]  code_q;
   logic [31:0] epc_q;
   logic        bd_q;
   logic        bva_wr_q;
   logic [31:0] bva_q;
   logic        eret_q;
   logic [31:0] tgt_q;

   logic        evt;
   logic        idle_evt;
   logic [4:0]  code_n;
   logic        bva_wr_n;
   logic [31:0] bva_n;

   assign evt      = MEM_Valid & ((|MEM_ExcReq) | MEM_Eret);
   assign idle_evt = ~rst & (state == IDLE) & evt;

   // Lowest set request bit wins; only address errors carry a BadVAddr.
   always_comb begin
      code_n   = 5'h00;
      bva_wr_n = 1'b0;
      bva_n    = 32'h0;
      if (MEM_ExcReq[0]) begin
         code_n = 5'h00;
      end else if (MEM_ExcReq[1]) begin
         code_n   = 5'h04;
         bva_wr_n = 1'b1;
         bva_n    = MEM_PC;
      end else if (MEM_ExcReq[2]) begin
         code_n = 5'h0a;
      end else if (MEM_ExcReq[3]) begin
         code_n = 5'h0c;
      end else if (MEM_ExcReq[4]) begin
         code_n = 5'h0d;
      end else if (MEM_ExcReq[5]) begin
         code_n = 5'h08;
      end else if (MEM_ExcReq[6]) begin
         code_n = 5'h09;
      end else if (MEM_ExcReq[7]) begin
         code_n   = 5'h04;
         bva_wr_n = 1'b1;
         bva_n    = MEM_BadVAddr;
      end else if (MEM_ExcReq[8]) begin
         code_n   = 5'h05;
         bva_wr_n = 1'b1;
         bva_n    = MEM_BadVAddr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 8'd0;
         code_q   <= 5'h00;
         epc_q    <= 32'h0;
         bd_q     <= 1'b0;
         bva_wr_q <= 1'b0;
         bva_q    <= 32'h0;
         eret_q   <= 1'b0;
         tgt_q    <= 32'h0;
      end else begin
         unique case (state)
            IDLE: begin
               if (evt) begin
                  state    <= DRAIN;
                  cnt      <= 8'd0;
                  code_q   <= code_n;
                  epc_q    <= MEM_InDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
                  bd_q     <= MEM_InDelaySlot;
                  bva_wr_q <= bva_wr_n;
                  bva_q    <= bva_n;
                  eret_q   <= ~(|MEM_ExcReq);
               end
            end
            DRAIN: begin
               cnt <= cnt + 8'd1;
               if (!Mem_Outstanding || cnt >= DRAIN_LAST)
                  state <= COMMIT;
            end
            COMMIT: begin
               tgt_q <= eret_q ? CP0_EPC : VEC_BASE;
               state <= REDIRECT;
            end
            REDIRECT: begin
               if (Redirect_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic in_commit;
   assign in_commit = (state == COMMIT);

   assign Kill_MEM       = idle_evt;
   assign Busy           = (state != IDLE);
   assign Stall_all      = Busy | idle_evt;
   assign Flush_all      = in_commit | (state == REDIRECT);
   assign CP0_WrEn       = in_commit & ~eret_q;
   assign CP0_ExlClr     = in_commit & eret_q;
   assign CP0_ExcCode    = CP0_WrEn ? code_q : 5'h00;
   assign CP0_EPC_out    = CP0_WrEn ? epc_q : 32'h0;
   assign CP0_BD         = CP0_WrEn & bd_q;
   assign CP0_BadVAddrWr = CP0_WrEn & bva_wr_q;
   assign CP0_BadVAddr   = CP0_BadVAddrWr ? bva_q : 32'h0;
   assign Redirect_valid = (state == REDIRECT);
   assign Redirect_PC    = Redirect_valid ? tgt_q : 32'h0;

endmodule

// File: tb/tb_exc_commit_seq.sv
// Directed bench for exc_commit_seq: cause priority, drain timing,
// ERET redirect handshake and reset behaviour.
module tb_exc_commit_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_Valid;
   logic [31:0] MEM_PC;
   logic        MEM_InDelaySlot;
   logic [8:0]  MEM_ExcReq;
   logic        MEM_Eret;
   logic [31:0] MEM_BadVAddr;
   logic [31:0] CP0_EPC;
   logic        Mem_Outstanding;
   logic        Redirect_ready;
   logic        Kill_MEM;
   logic        Stall_all;
   logic        Flush_all;
   logic        CP0_WrEn;
   logic        CP0_ExlClr;
   logic [4:0]  CP0_ExcCode;
   logic [31:0] CP0_EPC_out;
   logic        CP0_BD;
   logic        CP0_BadVAddrWr;
   logic [31:0] CP0_BadVAddr;
   logic        Redirect_valid;
   logic [31:0] Redirect_PC;
   logic        Busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   exc_commit_seq dut (
      .clk            (clk),
      .rst            (rst),
      .MEM_Valid      (MEM_Valid),
      .MEM_PC         (MEM_PC),
      .MEM_InDelaySlot(MEM_InDelaySlot),
      .MEM_ExcReq     (MEM_ExcReq),
      .MEM_Eret       (MEM_Eret),
      .MEM_BadVAddr   (MEM_BadVAddr),
      .CP0_EPC        (CP0_EPC),
      .Mem_Outstanding(Mem_Outstanding),
      .Redirect_ready (Redirect_ready),
      .Kill_MEM       (Kill_MEM),
      .Stall_all      (Stall_all),
      .Flush_all      (Flush_all),
      .CP0_WrEn       (CP0_WrEn),
      .CP0_ExlClr     (CP0_ExlClr),
      .CP0_ExcCode    (CP0_ExcCode),
      .CP0_EPC_out    (CP0_EPC_out),
      .CP0_BD         (CP0_BD),
      .CP0_BadVAddrWr (CP0_BadVAddrWr),
      .CP0_BadVAddr   (CP0_BadVAddr),
      .Redirect_valid (Redirect_valid),
      .Redirect_PC    (Redirect_PC),
      .Busy           (Busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs change and checks happen mid-cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic event_in(input logic [8:0] req, input logic eret,
                           input logic [31:0] pc, input logic bd,
                           input logic [31:0] bva);
      MEM_Valid       = 1'b1;
      MEM_ExcReq      = req;
      MEM_Eret        = eret;
      MEM_PC          = pc;
      MEM_InDelaySlot = bd;
      MEM_BadVAddr    = bva;
   endtask

   task automatic quiet();
      MEM_Valid       = 1'b0;
      MEM_ExcReq      = 9'h0;
      MEM_Eret        = 1'b0;
      MEM_InDelaySlot = 1'b0;
   endtask

   initial begin
      rst             = 1'b1;
      quiet();
      MEM_PC          = 32'h0;
      MEM_BadVAddr    = 32'h0;
      CP0_EPC         = 32'h0;
      Mem_Outstanding = 1'b0;
      Redirect_ready  = 1'b1;
      step();
      step();
      chk("rst_busy", {31'h0, Busy}, 32'h0);
      chk("rst_stall", {31'h0, Stall_all}, 32'h0);
      chk("rst_rpc", Redirect_PC, 32'h0);
      chk("rst_epc", CP0_EPC_out, 32'h0);
      rst = 1'b0;

      // Tr, fastest round trip
      step();
      event_in(9'h010, 1'b0, 32'hBFC0_0100, 1'b0, 32'h0);
      settle();
      chk("tr_T_kill", {31'h0, Kill_MEM}, 32'h1);
      chk("tr_T_stall", {31'h0, Stall_all}, 32'h1);
      chk("tr_T_busy", {31'h0, Busy}, 32'h0);
      step();
      quiet();
      settle();
      chk("tr_T1_busy", {31'h0, Busy}, 32'h1);
      chk("tr_T1_kill", {31'h0, Kill_MEM}, 32'h0);
      chk("tr_T1_wren", {31'h0, CP0_WrEn}, 32'h0);
      step();
      chk("tr_T2_wren", {31'h0, CP0_WrEn}, 32'h1);
      chk("tr_T2_flush", {31'h0, Flush_all}, 32'h1);
      chk("tr_T2_code", {27'h0, CP0_ExcCode}, 32'h0d);
      chk("tr_T2_epc", CP0_EPC_out, 32'hBFC0_0100);
      chk("tr_T2_bd", {31'h0, CP0_BD}, 32'h0);
      chk("tr_T2_bvawr", {31'h0, CP0_BadVAddrWr}, 32'h0);
      step();
      chk("tr_T3_rv", {31'h0, Redirect_valid}, 32'h1);
      chk("tr_T3_rpc", Redirect_PC, 32'hBFC0_0380);
      chk("tr_T3_wren", {31'h0, CP0_WrEn}, 32'h0);
      step();
      chk("tr_T4_busy", {31'h0, Busy}, 32'h0);
      chk("tr_T4_rv", {31'h0, Redirect_valid}, 32'h0);

      // Ov|Tr|Sys in a delay slot: Ov wins, EPC backs up to the branch
      event_in(9'h038, 1'b0, 32'h8000_1004, 1'b1, 32'h0);
      step();
      quiet();
      step();
      chk("ov_code", {27'h0, CP0_ExcCode}, 32'h0c);
      chk("ov_epc", CP0_EPC_out, 32'h8000_1000);
      chk("ov_bd", {31'h0, CP0_BD}, 32'h1);
      step();
      step();
      chk("ov_idle", {31'h0, Busy}, 32'h0);

      // AdES with data address
      event_in(9'h100, 1'b0, 32'h8000_0010, 1'b0, 32'h0000_0003);
      step();
      quiet();
      step();
      chk("ades_code", {27'h0, CP0_ExcCode}, 32'h05);
      chk("ades_bvawr", {31'h0, CP0_BadVAddrWr}, 32'h1);
      chk("ades_bva", CP0_BadVAddr, 32'h0000_0003);
      step();
      step();

      // AdEL on fetch: BadVAddr is the PC, ERET ignored
      event_in(9'h002, 1'b1, 32'h8000_0002, 1'b0, 32'h1234_5678);
      step();
      quiet();
      step();
      chk("adel_code", {27'h0, CP0_ExcCode}, 32'h04);
      chk("adel_bva", CP0_BadVAddr, 32'h8000_0002);
      chk("adel_exl", {31'h0, CP0_ExlClr}, 32'h0);
      step();
      step();

      // ERET with drain and a slow redirect acceptor
      CP0_EPC         = 32'h8000_2000;
      Mem_Outstanding = 1'b1;
      Redirect_ready  = 1'b0;
      event_in(9'h000, 1'b1, 32'h8000_0400, 1'b0, 32'h0);
      step();
      quiet();
      step();
      step();
      Mem_Outstanding = 1'b0;
      settle();
      chk("eret_T3_flush", {31'h0, Flush_all}, 32'h0);
      chk("eret_T3_stall", {31'h0, Stall_all}, 32'h1);
      step();
      chk("eret_T4_exl", {31'h0, CP0_ExlClr}, 32'h1);
      chk("eret_T4_wren", {31'h0, CP0_WrEn}, 32'h0);
      chk("eret_T4_code", {27'h0, CP0_ExcCode}, 32'h0);
      step();
      chk("eret_T5_rv", {31'h0, Redirect_valid}, 32'h1);
      chk("eret_T5_rpc", Redirect_PC, 32'h8000_2000);
      step();
      chk("eret_T6_rv", {31'h0, Redirect_valid}, 32'h1);
      chk("eret_T6_rpc", Redirect_PC, 32'h8000_2000);
      Redirect_ready = 1'b1;
      step();
      chk("eret_T7_idle", {31'h0, Busy}, 32'h0);

      // Drain timeout with the bus stuck busy
      Mem_Outstanding = 1'b1;
      event_in(9'h020, 1'b0, 32'h8000_0800, 1'b0, 32'h0);
      settle();
      chk("to_T_stall", {31'h0, Stall_all}, 32'h1);
      for (int i = 1; i <= 15; i++) begin
         step();
         quiet();
         settle();
         chk($sformatf("to_drain%0d_stall", i), {31'h0, Stall_all}, 32'h1);
         chk($sformatf("to_drain%0d_flush", i), {31'h0, Flush_all}, 32'h0);
      end
      step();
      chk("to_T16_wren", {31'h0, CP0_WrEn}, 32'h1);
      chk("to_T16_code", {27'h0, CP0_ExcCode}, 32'h08);
      Mem_Outstanding = 1'b0;
      step();
      chk("to_T17_rv", {31'h0, Redirect_valid}, 32'h1);
      step();
      chk("to_T18_idle", {31'h0, Busy}, 32'h0);

      // Reset while a redirect is pending
      Redirect_ready = 1'b0;
      event_in(9'h040, 1'b0, 32'h8000_0c00, 1'b0, 32'h0);
      step();
      quiet();
      step();
      step();
      chk("rr_T3_rv", {31'h0, Redirect_valid}, 32'h1);
      rst = 1'b1;
      step();
      chk("rr_rv", {31'h0, Redirect_valid}, 32'h0);
      chk("rr_rpc", Redirect_PC, 32'h0);
      chk("rr_busy", {31'h0, Busy}, 32'h0);
      chk("rr_stall", {31'h0, Stall_all}, 32'h0);
      chk("rr_flush", {31'h0, Flush_all}, 32'h0);
      chk("rr_wren", {31'h0, CP0_WrEn}, 32'h0);
      rst = 1'b0;
      Redirect_ready = 1'b1;

      // Requests without MEM_Valid are ignored
      event_in(9'h010, 1'b1, 32'h8000_1000, 1'b0, 32'h0);
      MEM_Valid = 1'b0;
      settle();
      chk("nv_kill", {31'h0, Kill_MEM}, 32'h0);
      chk("nv_stall", {31'h0, Stall_all}, 32'h0);
      step();
      chk("nv_busy", {31'h0, Busy}, 32'h0);
      quiet();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
